// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and multi-word block fill.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_nway #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2,
  parameter int CPUID    = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFFW = $clog2(BLKWORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int OW   = (OFFW > 0) ? OFFW : 1;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TLSB = 2 + OFFW + IDXW;
  localparam int TAGW = 32 - TLSB;

  if (SETS < 2 || (SETS & (SETS - 1)) != 0 || WAYS < 1 || (WAYS & (WAYS - 1)) != 0 ||
      BLKWORDS < 1 || (BLKWORDS & (BLKWORDS - 1)) != 0 || CPUID < 0) begin : g_param_check
    $error("icache_nway: invalid geometry parameters");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  logic            valid [WAYS][SETS];
  logic [TAGW-1:0] tags  [WAYS][SETS];
  logic [31:0]     data  [WAYS][SETS][BLKWORDS];
  logic [WW-1:0]   vptr  [SETS];

  logic [31:0]     base;
  logic [OW-1:0]   cnt;
  logic [WW-1:0]   victim;
  logic            by_ptr;

  logic [IDXW-1:0] idx, fidx;
  logic [OW-1:0]   off;
  logic [TAGW-1:0] tag;
  logic            hit_any, pick_ptr, miss_start, last_word, unused_bytes;
  logic [31:0]     hit_word;
  logic [WW-1:0]   pick;

  assign idx          = imemaddr[2+OFFW +: IDXW];
  assign off          = imemaddr[2 +: OW] & OW'(BLKWORDS - 1);
  assign tag          = imemaddr[31:TLSB];
  assign fidx         = base[2+OFFW +: IDXW];
  assign unused_bytes = ^imemaddr[1:0];

  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][idx] && tags[w][idx] == tag) begin
        hit_any  = 1'b1;
        hit_word = data[w][idx][off];
      end
    end
  end

  // Lowest-index invalid way wins; only a full set falls back to the round-robin pointer.
  always_comb begin
    pick     = vptr[idx];
    pick_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][idx]) begin
        pick     = WW'(w);
        pick_ptr = 1'b0;
      end
    end
  end

  assign ihit       = imemREN && state == IDLE && !iflush && hit_any;
  assign imemload   = ihit ? hit_word : '0;
  assign miss_start = imemREN && state == IDLE && !iflush && !hit_any;
  assign last_word  = cnt == OW'(BLKWORDS - 1);
  assign iREN       = state == FILL;
  assign iaddr      = (state == FILL) ? base + (32'(cnt) << 2) : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        vptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
      end
    end else if (iflush) begin
      state <= IDLE;
      cnt   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            victim <= pick;
            by_ptr <= pick_ptr;
            cnt    <= '0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            if (last_word) begin
              valid[victim][fidx] <= 1'b1;
              if (by_ptr) vptr[fidx] <= (vptr[fidx] + WW'(1)) & WW'(WAYS - 1);
              state <= IDLE;
            end else begin
              cnt <= cnt + OW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; valid bits alone decide what is visible.
  always_ff @(posedge CLK) begin
    if (miss_start) base <= {imemaddr[31:2+OFFW], {(2 + OFFW){1'b0}}};
    if (state == FILL && !iwait) begin
      data[victim][fidx][cnt] <= iload;
      if (last_word) tags[victim][fidx] <= base[31:TLSB];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit)       hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Randomised bench for icache_nway against a set/way occupancy model and a synthetic memory image.
module tb_icache_nway;
  localparam int SETS = 8, WAYS = 2, BLKWORDS = 2;
  localparam int OFFW = $clog2(BLKWORDS);
  localparam int IDXW = $clog2(SETS);
  localparam logic [31:0] BMASK = 32'(BLKWORDS * 4 - 1);

  logic CLK = 1'b0;
  logic nRST, imemREN, iflush, iwait, ihit, iREN;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total = 0, bad = 0;
  int fixed_wait = 0, wcnt = 0, cur_wait = 0, last_cycles = 0;
  bit wait_rand = 0;

  bit          mvalid [WAYS][SETS];
  int unsigned mtag   [WAYS][SETS];
  int          mptr   [SETS];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign iload = memf(iaddr);

  icache_nway #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS), .CPUID(0)) dut (
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  // Memory lane: each word is held busy for cur_wait cycles before being accepted.
  always @(negedge CLK) begin
    if (!iREN) begin
      wcnt = 0; iwait = 1'b0;
      cur_wait = wait_rand ? int'($urandom_range(0, 2)) : fixed_wait;
    end else if (wcnt < cur_wait) begin
      iwait = 1'b1; wcnt++;
    end else begin
      iwait = 1'b0; wcnt = 0;
      cur_wait = wait_rand ? int'($urandom_range(0, 2)) : fixed_wait;
    end
  end

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> (2 + OFFW)) % SETS);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (2 + OFFW + IDXW);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (mvalid[w][set_of(a)] && mtag[w][set_of(a)] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int s = set_of(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mvalid[w][s]) v = w;
    if (v < 0) begin
      v = mptr[s];
      mptr[s] = (mptr[s] + 1) % WAYS;
    end
    mvalid[v][s] = 1'b1;
    mtag[v][s] = tag_of(a);
  endfunction

  function automatic void model_clear(input bit ptrs);
    for (int s = 0; s < SETS; s++) begin
      if (ptrs) mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mvalid[w][s] = 1'b0;
    end
  endfunction

  task automatic run_fill(input logic [31:0] base, input bit do_sw, input logic [31:0] sw);
    int words = 0;
    last_cycles = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK); #1;
      if (!iREN) break;
      last_cycles++;
      total++;
      if (ihit !== 1'b0 || iaddr !== base + 32'(words * 4)) begin
        bad++;
        $display("FAIL fill_cycle: ihit=%0b iaddr=%h, expected ihit=0 iaddr=%h", ihit, iaddr, base + 32'(words * 4));
      end
      if (do_sw) imemaddr = sw;
      if (!iwait) words++;
    end
    total++;
    if (words != BLKWORDS || iREN !== 1'b0) begin
      bad++;
      $display("FAIL fill_words: got %0d words iREN=%0b, expected %0d words iREN=0", words, iREN, BLKWORDS);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, output bit got_hit);
    bit exp;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a; iflush = 1'b0;
    #1;
    exp = model_hit(a);
    got_hit = ihit;
    total++;
    if (ihit !== exp || imemload !== (exp ? memf(a) : 32'h0)) begin
      bad++;
      $display("FAIL fetch %h: ihit=%0b load=%h, expected ihit=%0b load=%h", a, ihit, imemload, exp, exp ? memf(a) : 32'h0);
    end
    if (!exp) begin
      run_fill(a & ~BMASK, 1'b0, 32'h0);
      model_fill(a);
      total++;
      if (ihit !== 1'b1 || imemload !== memf(a)) begin
        bad++;
        $display("FAIL after_fill %h: ihit=%0b load=%h, expected ihit=1 load=%h", a, ihit, imemload, memf(a));
      end
    end
  endtask

  task automatic flush_cycle();
    @(negedge CLK);
    iflush = 1'b1; imemREN = 1'b1; imemaddr = 32'($urandom_range(0, 255)) << 2;
    #1;
    total++;
    if (ihit !== 1'b0 || imemload !== 32'h0) begin
      bad++;
      $display("FAIL flush_hit: ihit=%0b load=%h, expected 0 and 0", ihit, imemload);
    end
    model_clear(1'b0);
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    imemREN = 1'b0; iflush = 1'b0; imemaddr = 32'($urandom_range(0, 255)) << 2;
    #1;
    total++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0) begin
      bad++;
      $display("FAIL idle: ihit=%0b iREN=%0b load=%h, expected 0 0 0", ihit, iREN, imemload);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h100; iflush = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: ihit=%0b load=%h iREN=%0b iaddr=%h, expected all 0", ihit, imemload, iREN, iaddr);
    end
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
    end
`endif
    imemREN = 1'b0;
    model_clear(1'b1);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_fill();
    bit h;
    wait_rand = 0; fixed_wait = 2;
    do_fetch(32'h100, h);
    total++;
    if (h !== 1'b0 || last_cycles != 6) begin
      bad++;
      $display("FAIL cold_fill: hit=%0b cycles=%0d, expected hit=0 cycles=6", h, last_cycles);
    end
    do_fetch(32'h104, h);
    total++;
    if (h !== 1'b1) begin
      bad++;
      $display("FAIL same_block_hit: got %0b, expected 1", h);
    end
    idle_cycle();
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
      bad++;
      $display("FAIL stats: hit=%0d miss=%0d, expected 2 1", hit_count, miss_count);
    end
`endif
    do_fetch(32'h30C, h);
  endtask

  task automatic test_flush_idle();
    bit h;
    flush_cycle();
    do_fetch(32'h104, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_refetch: hit=%0b, expected 0", h);
    end
  endtask

  task automatic test_evict();
    bit h;
    flush_cycle();
    wait_rand = 1;
    do_fetch(32'h000, h);
    do_fetch(32'h040, h);
    do_fetch(32'h080, h);
    do_fetch(32'h040, h);
    total++;
    if (h !== 1'b1) begin
      bad++;
      $display("FAIL evict_keep: 0x040 hit=%0b, expected 1", h);
    end
    do_fetch(32'h000, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL evict_victim: 0x000 hit=%0b, expected 0", h);
    end
  endtask

  task automatic test_flush_mid_fill();
    flush_cycle();
    wait_rand = 0; fixed_wait = 0;
    @(negedge CLK);
    iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h200;
    @(negedge CLK); #1;
    total++;
    if (iREN !== 1'b1 || iaddr !== 32'h200) begin
      bad++;
      $display("FAIL abort_word0: iREN=%0b iaddr=%h, expected 1 00000200", iREN, iaddr);
    end
    @(negedge CLK);
    iflush = 1'b1;
    #1;
    total++;
    if (iREN !== 1'b1 || iaddr !== 32'h204 || ihit !== 1'b0) begin
      bad++;
      $display("FAIL abort_word1: iREN=%0b iaddr=%h ihit=%0b, expected 1 00000204 0", iREN, iaddr, ihit);
    end
    model_clear(1'b0);
    @(negedge CLK);
    iflush = 1'b0;
    #1;
    total++;
    if (iREN !== 1'b0 || ihit !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: iREN=%0b ihit=%0b, expected 0 0", iREN, ihit);
    end
    run_fill(32'h200, 1'b0, 32'h0);
    model_fill(32'h200);
    total++;
    if (ihit !== 1'b1 || imemload !== memf(32'h200)) begin
      bad++;
      $display("FAIL abort_refill: ihit=%0b load=%h, expected 1 %h", ihit, imemload, memf(32'h200));
    end
  endtask

  task automatic test_addr_switch();
    bit h;
    flush_cycle();
    wait_rand = 1;
    @(negedge CLK);
    iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h100;
    run_fill(32'h100, 1'b1, 32'h200);
    model_fill(32'h100);
    total++;
    if (ihit !== 1'b0) begin
      bad++;
      $display("FAIL switch_miss: 0x200 ihit=%0b, expected 0", ihit);
    end
    run_fill(32'h200, 1'b0, 32'h0);
    model_fill(32'h200);
    total++;
    if (ihit !== 1'b1 || imemload !== memf(32'h200)) begin
      bad++;
      $display("FAIL switch_fill: ihit=%0b load=%h, expected 1 %h", ihit, imemload, memf(32'h200));
    end
    do_fetch(32'h100, h);
    total++;
    if (h !== 1'b1) begin
      bad++;
      $display("FAIL switch_orig: 0x100 hit=%0b, expected 1", h);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit h;
    wait_rand = 0; fixed_wait = 1;
    do_fetch(32'h040, h);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h3C0;
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK); #1;
    total++;
    if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_fill: iREN=%0b ihit=%0b iaddr=%h, expected 0 0 0", iREN, ihit, iaddr);
    end
    nRST = 1'b1; imemREN = 1'b0;
    model_clear(1'b1);
    do_fetch(32'h040, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL reset_cleared: 0x040 hit=%0b, expected 0", h);
    end
  endtask

  task automatic test_random();
    bit h;
    int r;
    wait_rand = 1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) flush_cycle();
      else if (r == 1) idle_cycle();
      else do_fetch(32'($urandom_range(0, 255)) << 2, h);
    end
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_flush_idle();
    test_evict();
    test_flush_mid_fill();
    test_addr_switch();
    test_reset_mid_fill();
    test_random();
    idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
